fifo_pop_stream: RTL
====================

Name: fifo_pop_stream

Overview:
- Reader for the push/pop queue interface used across the codebase: it drains a queue's pop side (empty/data/pop) and presents the data as a valid/ready stream.
- A 2-entry output buffer keeps full throughput while removing any combinational path from downstream ready_i to the queue's pop_o.
- Sits between any common-cells queue and a valid/ready consumer.

Parameters:
DATA_WIDTH, 32, width of the default payload type
dtype, logic [DATA_WIDTH-1:0], payload type; must match the upstream queue
CNT_WIDTH, 16, width of the delivered-beat and stall counters

Ports:
clk_i  input  1  clock
rst_ni  input  1  reset; one clock; reset is synchronous and active-low
flush_i  input  1  discard buffered beats and clear count_o; wire to the same flush as the upstream queue
empty_i  input  1  upstream queue empty
data_i  input  dtype  upstream head data, combinational from the queue
pop_o  output  1  pop upstream head this cycle
valid_o  output  1  output beat valid
ready_i  input  1  downstream accepts beat
data_o  output  dtype  output beat data
usage_o  output  2  buffered beats (0..2)
count_o  output  CNT_WIDTH  beats delivered since reset/flush; wraps
stall_cnt_o  output  CNT_WIDTH  backpressure cycles (optional feature)

Behaviour:
- State machine, buffer registers A (head) and B (second). States ST_EMPTY, ST_ONE, ST_TWO.
- Handshake definition: hs = valid_o & ready_i.
- Pop: pop_o = rst_ni & ~flush_i & ~empty_i & (state != ST_TWO). pop_o never depends on ready_i.
- Output: valid_o = (state != ST_EMPTY) & ~flush_i. data_o = A. usage_o = 0/1/2 per state.
- Transitions in ST_EMPTY:
  - pop -> ST_ONE, A <= data_i.
  - no pop -> stay.
- Transitions in ST_ONE:
  - pop & hs -> ST_ONE, A <= data_i.
  - pop & ~hs -> ST_TWO, B <= data_i.
  - ~pop & hs -> ST_EMPTY.
  - otherwise hold.
- Transitions in ST_TWO:
  - hs -> ST_ONE, A <= B.
  - otherwise hold; no pop issued.
- Latency: a beat popped in cycle N is visible on data_o in cycle N+1 at the earliest. Steady-state throughput is 1 beat/cycle with ready_i held high.
- Data stability: while valid_o & ~ready_i, data_o and valid_o stay stable (AXI-stream rule). The only exception is flush.
- count_o: increments by 1 on each hs and wraps at 2^CNT_WIDTH.
- Flush: next state ST_EMPTY, count_o <= 0, A/B contents don't-care. In the flush cycle valid_o = 0 and pop_o = 0, so no hs and no pop occur.
- Reset (synchronous, sampled at posedge with rst_ni low) takes priority over flush. Reset values: state ST_EMPTY, valid_o 0, usage_o 0, count_o 0, stall_cnt_o 0, A/B 0. pop_o is 0 in any cycle with rst_ni low.
- Reset mid-operation: buffered beats are dropped. The upstream queue must be reset in the same cycle.
- Empty boundary: empty_i = 1 blocks pop regardless of state. data_i is ignored whenever pop_o = 0.
- Full boundary: ST_TWO never pops, even when ready_i = 1. The pop resumes the following cycle in ST_ONE.

Optional Feature:
Macro FIFO_POP_STREAM_STALL_CNT_EN.
- Defined: stall_cnt_o increments each cycle with valid_o & ~ready_i. It saturates at all-ones and is cleared by reset and by flush.
- Undefined: stall_cnt_o is tied to '0 and no counter flops are synthesised. The port list is identical in both builds.

Decomposition:
- Package fifo_pop_stream_pkg holds:
  - state_e enum: ST_EMPTY = 2'b00, ST_ONE = 2'b01, ST_TWO = 2'b10.
  - Localparam USAGE_WIDTH = 2.
- One sub-module is natural: fifo_pop_stream_buf, holding the A/B registers plus load/shift controls. The FSM, pop logic and counters stay in the top.

Test Plan:
- Reset then preload 3 entries upstream with ready_i = 1 -> pop_o high cycles 0..2; valid_o high cycles 1..3 with data 0xA0, 0xA1, 0xA2; count_o = 3.
- ready_i = 0 with 5 entries upstream -> exactly 2 pops, usage_o = 2, pop_o stays 0, data_o = first entry and stable. Then ready_i = 1 -> remaining 3 beats delivered in order, count_o = 5.
- ready_i toggling 1/0 each cycle over 8 entries -> order preserved, no duplicate or lost beat, pop_o never asserted in ST_TWO.
- flush_i asserted in ST_TWO with ready_i = 1 -> that cycle valid_o = 0 and pop_o = 0. Next cycle usage_o = 0 and count_o = 0.
- rst_ni low for 1 cycle mid-stream, with flush_i also high -> next cycle all outputs at reset values. No pop while rst_ni is low.
- With FIFO_POP_STREAM_STALL_CNT_EN defined and CNT_WIDTH = 4: hold valid_o & ~ready_i for 20 cycles -> stall_cnt_o saturates at 15. Without the macro -> stall_cnt_o stays 0.

Source files
------------

// File: rtl/fifo_pop_stream_pkg.sv
// fifo_pop_stream_pkg: shared state encoding and widths for the queue-to-stream reader.
package fifo_pop_stream_pkg;
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;
  localparam int unsigned USAGE_WIDTH = 2;
endpackage

// File: rtl/fifo_pop_stream_buf.sv
// fifo_pop_stream_buf: two-entry output buffer, A is the presented head, B the spill slot.
module fifo_pop_stream_buf #(
  parameter type dtype = logic [31:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ld_a,
  input  logic ld_b,
  input  logic shift,
  input  dtype data_i,
  output dtype a_o
);
  dtype b_q;
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      a_o <= '0;
      b_q <= '0;
    end else begin
      a_o <= shift ? b_q : ld_a ? data_i : a_o;
      b_q <= ld_b ? data_i : b_q;
    end
endmodule

// File: rtl/fifo_pop_stream.sv
// fifo_pop_stream: drains a queue pop side into a valid/ready stream with no ready-to-pop path.
// Optional backpressure counter: define FIFO_POP_STREAM_STALL_CNT_EN.
module fifo_pop_stream
  import fifo_pop_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter type dtype = logic [DATA_WIDTH-1:0],
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   empty_i,
  input  dtype                   data_i,
  output logic                   pop_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output dtype                   data_o,
  output logic [USAGE_WIDTH-1:0] usage_o,
  output logic [CNT_WIDTH-1:0]   count_o,
  output logic [CNT_WIDTH-1:0]   stall_cnt_o
);
  state_e state_q;
  logic hs, ld_a, ld_b, shift;
  assign pop_o   = rst_ni & ~flush_i & ~empty_i & (state_q != ST_TWO);
  assign valid_o = (state_q != ST_EMPTY) & ~flush_i;
  assign hs      = valid_o & ready_i;
  assign usage_o = state_q;
  // A is refilled when empty or when its beat leaves; B only catches the overflow beat.
  assign ld_a  = pop_o & ((state_q == ST_EMPTY) | ((state_q == ST_ONE) & hs));
  assign ld_b  = pop_o & (state_q == ST_ONE) & ~hs;
  assign shift = (state_q == ST_TWO) & hs;
  always_ff @(posedge clk_i)
    if (!rst_ni || flush_i) begin
      state_q <= ST_EMPTY;
      count_o <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: if (pop_o) state_q <= ST_ONE;
        ST_ONE:   if (pop_o & ~hs) state_q <= ST_TWO;
                  else if (~pop_o & hs) state_q <= ST_EMPTY;
        ST_TWO:   if (hs) state_q <= ST_ONE;
        default:  state_q <= ST_EMPTY;
      endcase
      if (hs) count_o <= count_o + CNT_WIDTH'(1);
    end
  fifo_pop_stream_buf #(.dtype(dtype)) u_buf (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .ld_a  (ld_a),
    .ld_b  (ld_b),
    .shift (shift),
    .data_i(data_i),
    .a_o   (data_o)
  );
`ifdef FIFO_POP_STREAM_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_q;
  always_ff @(posedge clk_i)
    if (!rst_ni || flush_i) stall_q <= '0;
    else if (valid_o & ~ready_i & ~&stall_q) stall_q <= stall_q + CNT_WIDTH'(1);
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif
endmodule
